// File: rtl/mesm6_alu_mc_if.sv
// mesm6_alu_mc_if -- request/result bundle between the mesm6 microsequencer
// and the multicycle ALU.
//
// Signals:
//   start    request strobe, sampled by the ALU only while idle
//   alu_op   operation code, captured with start
//   alu_a    operand A, captured with start
//   alu_b    operand B / offset / shift descriptor, captured with start
//   alu_r    result word (registered)
//   alu_y    low/extension word (registered)
//   busy     operation in flight
//   done     one-cycle completion pulse; alu_r/alu_y valid from this cycle
//   illegal  pulses with done for an unsupported opcode
//
// Modports: master = microsequencer side, slave = ALU side.
interface mesm6_alu_mc_if #(
    parameter int WIDTH = 48,
    parameter int OP_W  = 4
);
    logic             start;
    logic [OP_W-1:0]  alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_r;
    logic [WIDTH-1:0] alu_y;
    logic             busy;
    logic             done;
    logic             illegal;

    modport master (
        output start, alu_op, alu_a, alu_b,
        input  alu_r, alu_y, busy, done, illegal
    );

    modport slave (
        input  start, alu_op, alu_a, alu_b,
        output alu_r, alu_y, busy, done, illegal
    );
endinterface

// File: rtl/mesm6_alu_mc.sv
// mesm6_alu_mc -- multicycle ALU for the mesm6 execute path.
//
// One operation per start/done handshake. Logic, add/sub and offset ops
// finish with done two cycles after the accepting edge; SHIFT takes one
// extra cycle per bit (count clamped to WIDTH), MUL one cycle per bit of B.
//
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high; aborts any operation in flight
//   bus    mesm6_alu_mc_if.slave (start/alu_op/alu_a/alu_b in,
//          alu_r/alu_y/busy/done/illegal out)
//
// Build option: define MESM6_ALU_MUL_EN to include the shift-add multiplier.
// Without it, opcode 10 completes as an illegal opcode.
module mesm6_alu_mc #(
    parameter int WIDTH = 48,
    parameter int OP_W  = 4
) (
    input logic           clk,
    input logic           reset,
    mesm6_alu_mc_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;

    typedef enum logic [OP_W-1:0] {
        OP_NOP    = 0,
        OP_NOP_B  = 1,
        OP_AND    = 2,
        OP_OR     = 3,
        OP_NOT    = 4,
        OP_XOR    = 5,
        OP_ADD    = 6,
        OP_SUB    = 7,
        OP_PLUS_O = 8,
        OP_SHIFT  = 9,
        OP_MUL    = 10
    } op_t;

    state_t             state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   r_q, r_d, y_q, y_d;
    logic [2*WIDTH-1:0] w_q, w_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ill_q, ill_d;

    logic [CNT_W-1:0]   shamt;
    logic               shr;
    logic [WIDTH-1:0]   offset;
    logic [WIDTH:0]     arith;
    logic [2*WIDTH-1:0] step_w;
`ifdef MESM6_ALU_MUL_EN
    logic [WIDTH:0]     mul_sum;
`endif

    // Working register w_q: shifts keep {hi,lo} of the 2*WIDTH shifter,
    // MUL keeps {partial product, remaining multiplier bits}.
    always_comb begin
        shamt  = (b_q[CNT_W-1:0] > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : b_q[CNT_W-1:0];
        shr    = b_q[CNT_W];
        offset = WIDTH'({~b_q[4], b_q[3:0], 2'b00});
`ifdef MESM6_ALU_MUL_EN
        mul_sum = {1'b0, w_q[2*WIDTH-1:WIDTH]} + (w_q[0] ? {1'b0, a_q} : '0);
        if (op_q == OP_MUL)
            step_w = {mul_sum, w_q[WIDTH-1:1]};
        else
`endif
        step_w = shr ? (w_q >> 1) : (w_q << 1);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        y_d     = y_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        arith   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.alu_op;
                    a_d     = bus.alu_a;
                    b_d     = bus.alu_b;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_DONE;
                ill_d   = 1'b0;
                case (op_q)
                    OP_NOP:   begin r_d = a_q;          y_d = '0; end
                    OP_NOP_B: begin r_d = b_q;          y_d = '0; end
                    OP_AND:   begin r_d = a_q & b_q;    y_d = '0; end
                    OP_OR:    begin r_d = a_q | b_q;    y_d = '0; end
                    OP_NOT:   begin r_d = ~a_q;         y_d = '0; end
                    OP_XOR:   begin r_d = a_q ^ b_q;    y_d = '0; end
                    OP_PLUS_O: begin r_d = a_q + offset; y_d = '0; end
                    OP_ADD: begin
                        arith = {1'b0, a_q} + {1'b0, b_q};
                        r_d   = arith[WIDTH-1:0];
                        y_d   = WIDTH'(arith[WIDTH]);
                    end
                    OP_SUB: begin
                        // Top bit of the widened difference is the borrow.
                        arith = {1'b0, a_q} - {1'b0, b_q};
                        r_d   = arith[WIDTH-1:0];
                        y_d   = WIDTH'(arith[WIDTH]);
                    end
                    OP_SHIFT: begin
                        if (shamt == '0) begin
                            r_d = a_q;
                            y_d = '0;
                        end else begin
                            w_d     = shr ? {a_q, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, a_q};
                            cnt_d   = shamt;
                            state_d = S_ITER;
                        end
                    end
`ifdef MESM6_ALU_MUL_EN
                    OP_MUL: begin
                        w_d     = {{WIDTH{1'b0}}, b_q};
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = S_ITER;
                    end
`endif
                    default: begin
                        r_d   = '0;
                        y_d   = '0;
                        ill_d = 1'b1;
                    end
                endcase
            end
            S_ITER: begin
                w_d   = step_w;
                cnt_d = cnt_q - 1'b1;
                // Results are published only on the last step so alu_r/alu_y
                // keep the previous operation's values until done.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    if (op_q == OP_SHIFT && !shr) begin
                        r_d = step_w[WIDTH-1:0];
                        y_d = step_w[2*WIDTH-1:WIDTH];
                    end else begin
                        r_d = step_w[2*WIDTH-1:WIDTH];
                        y_d = step_w[WIDTH-1:0];
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            y_q     <= y_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.alu_r   = r_q;
    assign bus.alu_y   = y_q;
    assign bus.busy    = (state_q == S_EXEC) || (state_q == S_ITER);
    assign bus.done    = (state_q == S_DONE);
    assign bus.illegal = (state_q == S_DONE) && ill_q;
endmodule

// File: tb/tb_mesm6_alu_mc.sv
// tb_mesm6_alu_mc -- self-checking bench for mesm6_alu_mc (WIDTH=48).
// Directed vector table, randomized ops against a plain-arithmetic model,
// and hand sequences for reset, held start and mid-operation abort.
module tb_mesm6_alu_mc;
    localparam int W = 48;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mesm6_alu_mc_if #(.WIDTH(W), .OP_W(4)) bus ();

    mesm6_alu_mc #(.WIDTH(W), .OP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [W-1:0] y;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [W-1:0] rand48();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[W-1:0];
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, b, r, y,
                                input logic ill, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.r = r; v.y = y; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    // Reference model straight from the operation definitions.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, b,
                                  output logic [W-1:0] r, y, output logic ill, output int lat);
        logic [2*W-1:0] t;
        logic [W:0]     s;
        int             n;
        r = '0; y = '0; ill = 1'b0; lat = 2;
        case (op)
            4'd0: r = a;
            4'd1: r = b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = ~a;
            4'd5: r = a ^ b;
            4'd6: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; y = {47'h0, s[W]}; end
            4'd7: begin r = a - b; y = {47'h0, (a < b)}; end
            4'd8: r = a + W'((b[4] ? 0 : 64) + int'(b[3:0]) * 4);
            4'd9: begin
                n = int'(b[5:0]);
                if (n > W) n = W;
                if (b[6]) begin
                    t = {a, 48'h0} >> n;
                    r = t[2*W-1:W]; y = t[W-1:0];
                end else begin
                    t = {48'h0, a} << n;
                    r = t[W-1:0]; y = t[2*W-1:W];
                end
                lat = 2 + n;
            end
            4'd10: begin
`ifdef MESM6_ALU_MUL_EN
                t = {48'h0, a} * {48'h0, b};
                r = t[2*W-1:W]; y = t[W-1:0];
                lat = 2 + W;
`else
                ill = 1'b1;
`endif
            end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op in the first idle cycle and wait (bounded) for done.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, b,
                          output logic [W-1:0] r, y, output logic ill,
                          output int lat, output bit busy_ok);
        bit got;
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = op; bus.alu_a = a; bus.alu_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.alu_op = 4'($urandom); bus.alu_a = rand48(); bus.alu_b = rand48();
        lat = 0; busy_ok = 1'b1; got = 1'b0; r = '0; y = '0; ill = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.done) begin
                got = 1'b1;
                r = bus.alu_r; y = bus.alu_y; ill = bus.illegal;
                if (bus.busy) busy_ok = 1'b0;
            end else if (!bus.busy) begin
                busy_ok = 1'b0;
            end
        end
        if (!got) lat = -1;
    endtask

    task automatic check_op(input string name, input logic [3:0] op, input logic [W-1:0] a, b,
                            input logic [W-1:0] er, ey, input logic eill, input int elat);
        logic [W-1:0] r, y;
        logic         ill;
        int           lat;
        bit           busy_ok;
        run_op(op, a, b, r, y, ill, lat, busy_ok);
        chk({name, "_r"},    64'(r),   64'(er));
        chk({name, "_y"},    64'(y),   64'(ey));
        chk({name, "_ill"},  64'(ill), 64'(eill));
        chk({name, "_lat"},  64'(lat), 64'(elat));
        chk({name, "_busy"}, 64'(busy_ok), 64'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb, mr, my;
        logic         mill;
        int           mlat;
        logic [3:0]   op;
        int           sel;
        int           d1, d2;
        bit           seen;
        logic [3:0]   long_op;
        logic [W-1:0] long_b;

        n_tests = 0; n_fail = 0;
        bus.start = 1'b0; bus.alu_op = '0; bus.alu_a = '0; bus.alu_b = '0;

        // Reset with start held high: nothing may be accepted.
        reset = 1'b1;
        bus.start = 1'b1; bus.alu_op = 4'd6; bus.alu_a = rand48(); bus.alu_b = rand48();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_busy", c), 64'(bus.busy), 64'd0);
            chk($sformatf("rst%0d_done", c), 64'(bus.done), 64'd0);
            chk($sformatf("rst%0d_ill", c), 64'(bus.illegal), 64'd0);
            chk($sformatf("rst%0d_r", c), 64'(bus.alu_r), 64'd0);
            chk($sformatf("rst%0d_y", c), 64'(bus.alu_y), 64'd0);
        end
        bus.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        chk("post_rst_done", 64'(bus.done), 64'd0);

        // Directed vectors.
        tbl.push_back(mk(4'd6, 48'hFFFF_FFFF_FFFF, 48'h1, 48'h0, 48'h1, 1'b0, 2));
        tbl.push_back(mk(4'd7, 48'h3, 48'h5, 48'hFFFF_FFFF_FFFE, 48'h1, 1'b0, 2));
        tbl.push_back(mk(4'd7, 48'h5, 48'h3, 48'h2, 48'h0, 1'b0, 2));
        tbl.push_back(mk(4'd8, 48'h100, 48'h05, 48'h154, 48'h0, 1'b0, 2));
        tbl.push_back(mk(4'd8, 48'h100, 48'h13, 48'h10C, 48'h0, 1'b0, 2));
        tbl.push_back(mk(4'd9, 48'h8000_0000_0001, 48'h04, 48'h10, 48'h8, 1'b0, 6));
        tbl.push_back(mk(4'd9, 48'h8000_0000_0001, 48'h41, 48'h4000_0000_0000, 48'h8000_0000_0000, 1'b0, 3));
        tbl.push_back(mk(4'd9, 48'h8000_0000_0001, 48'h00, 48'h8000_0000_0001, 48'h0, 1'b0, 2));
        tbl.push_back(mk(4'd9, 48'h8000_0000_0001, 48'h3F, 48'h0, 48'h8000_0000_0001, 1'b0, 50));
        tbl.push_back(mk(4'd9, 48'h8000_0000_0001, 48'h7F, 48'h0, 48'h8000_0000_0001, 1'b0, 50));
`ifdef MESM6_ALU_MUL_EN
        tbl.push_back(mk(4'd10, 48'hFFFF_FFFF_FFFF, 48'h2, 48'h1, 48'hFFFF_FFFF_FFFE, 1'b0, 50));
`else
        tbl.push_back(mk(4'd10, 48'hFFFF_FFFF_FFFF, 48'h2, 48'h0, 48'h0, 1'b1, 2));
`endif
        tbl.push_back(mk(4'd12, 48'h1234, 48'h5678, 48'h0, 48'h0, 1'b1, 2));
        tbl.push_back(mk(4'd0, 48'h1234_5678_9ABC, 48'h1, 48'h1234_5678_9ABC, 48'h0, 1'b0, 2));
        tbl.push_back(mk(4'd1, 48'h1, 48'hABC, 48'hABC, 48'h0, 1'b0, 2));
        tbl.push_back(mk(4'd2, 48'hFF00_FF00_FF00, 48'h0FF0_0FF0_0FF0, 48'h0F00_0F00_0F00, 48'h0, 1'b0, 2));
        tbl.push_back(mk(4'd3, 48'hFF00_FF00_FF00, 48'h0FF0_0FF0_0FF0, 48'hFFF0_FFF0_FFF0, 48'h0, 1'b0, 2));
        tbl.push_back(mk(4'd5, 48'hFF00_FF00_FF00, 48'h0FF0_0FF0_0FF0, 48'hF0F0_F0F0_F0F0, 48'h0, 1'b0, 2));
        tbl.push_back(mk(4'd4, 48'h0, 48'h0, 48'hFFFF_FFFF_FFFF, 48'h0, 1'b0, 2));

        foreach (tbl[i])
            check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                     tbl[i].r, tbl[i].y, tbl[i].ill, tbl[i].lat);

        // Start held high: DONE-cycle start ignored, next accept in the following cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 4'd1; bus.alu_b = 48'h5A5;
        d1 = -1; d2 = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
            end
        end
        bus.start = 1'b0;
        chk("held_done1", 64'(d1), 64'd2);
        chk("held_done2", 64'(d2), 64'd5);
        chk("held_r", 64'(bus.alu_r), 64'h5A5);

        // Long op interrupted: ignored start, held outputs, then reset abort.
        check_op("pre_abort_not", 4'd4, 48'h0, 48'h0, 48'hFFFF_FFFF_FFFF, 48'h0, 1'b0, 2);
`ifdef MESM6_ALU_MUL_EN
        long_op = 4'd10; long_b = 48'h2;
`else
        long_op = 4'd9;  long_b = 48'h30;
`endif
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = long_op; bus.alu_a = 48'hFFFF_FFFF_FFFF; bus.alu_b = long_b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (bus.done || !bus.busy) seen = 1'b1;
            if (c == 10) begin
                bus.start = 1'b1; bus.alu_op = 4'd4; bus.alu_a = 48'h0;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("mid_busy_nodone", 64'(seen), 64'd0);
        chk("mid_hold_r", 64'(bus.alu_r), 64'hFFFF_FFFF_FFFF);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_r", 64'(bus.alu_r), 64'd0);
        chk("abort_y", 64'(bus.alu_y), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("abort_quiet", 64'(seen), 64'd0);
        check_op("post_abort_not", 4'd4, 48'h0, 48'h0, 48'hFFFF_FFFF_FFFF, 48'h0, 1'b0, 2);

        // Randomized ops against the model, biased towards SHIFT/MUL.
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 19);
            op  = (sel < 16) ? 4'(sel) : ((sel < 18) ? 4'd9 : 4'd10);
            ra  = rand48();
            rb  = rand48();
            model(op, ra, rb, mr, my, mill, mlat);
            check_op($sformatf("rnd%0d_op%0d", i, op), op, ra, rb, mr, my, mill, mlat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mesm6_alu_mc.md
# mesm6_alu_mc

Multicycle, width-parametrised ALU for the mesm6 core, replacing the single-cycle combinational ALU on the execute path. It accepts one operation per start/done handshake and returns a WIDTH-bit result plus a WIDTH-bit low/extension word. Logic and add operations complete in one cycle; shifts and multiply iterate one bit per clock. The microsequencer issues `start` and stalls until `done`.

## Interface
- `WIDTH`, 48: data word width (BESM-6 word); legal range 8..64.
- `OP_W`, 4: width of `alu_op`.
- `CNT_W`, derived `$clog2(WIDTH+1)`: shift-count field width, 6 for WIDTH=48.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `alu_op`  in  OP_W  operation code, captured with `start`.
- `alu_a`  in  WIDTH  operand A, captured with `start`.
- `alu_b`  in  WIDTH  operand B or offset/shift descriptor, captured with `start`.
- `alu_r`  out  WIDTH  result, registered.
- `alu_y`  out  WIDTH  low/extension word, registered.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; `alu_r`/`alu_y` are valid from this cycle.
- `illegal`  out  1  pulses with `done` for an unsupported opcode.

## Operation
- Opcodes: 0 NOP (r=a), 1 NOP_B (r=b), 2 AND, 3 OR, 4 NOT (r=~a), 5 XOR, 6 ADD, 7 SUB (a−b), 8 PLUS_OFFSET, 9 SHIFT, 10 MUL, 11–15 illegal.
- Arithmetic is modulo 2^WIDTH.
  - ADD: `alu_y[0]` = carry-out, other y bits 0.
  - SUB: `alu_y[0]` = borrow (1 when a<b unsigned).
- PLUS_OFFSET: r = a + zero-extended {~b[4], b[3:0], 2'b00}; y=0.
- All other single-cycle ops: y=0.
- SHIFT:
  - n = b[CNT_W-1:0], clamped to WIDTH. b[CNT_W]=0 shifts left, 1 shifts right (logical).
  - Left: {y,r} = {0,a} << n.
  - Right: {r,y} = {a,0} >> n.
  - Shifted-out bits land in y.
- MUL: unsigned WIDTH×WIDTH; r = high word, y = low word. Shift-add, one partial product per cycle.
- Illegal opcode: r=0, y=0, `illegal`=1 for the `done` cycle.
- FSM states:
  - IDLE: `start` latches operands and goes to EXEC.
  - EXEC: single-cycle ops go to DONE. SHIFT/MUL load the counter and go to ITER, or go straight to DONE when n=0.
  - ITER: one step per cycle; leave when the counter reaches 0.
  - DONE: assert `done`, return to IDLE.
- `start` while not IDLE is ignored; no queueing.
- `alu_r`/`alu_y` hold their values until the next operation's `done`.
- Operand inputs may change freely after the accepting cycle.

## Timing
- Reset values: `alu_r`=0, `alu_y`=0, `busy`=0, `done`=0, `illegal`=0, FSM=IDLE, counter=0.
- `reset` mid-operation aborts at the next edge. No `done` is produced for the aborted operation.
- Latency, measured from the `start` edge to the `done`-high cycle:
  - Single-cycle ops: 2.
  - SHIFT: 2+n (n after clamping).
  - MUL: 2+WIDTH (50 at WIDTH=48).
- `busy` is high in EXEC and ITER, low in DONE and IDLE.
- `start` asserted in the DONE cycle is ignored. The earliest accepted back-to-back `start` is in the cycle after `done`.
- `reset` and `start` in the same cycle: reset wins.

## Configuration
- `MESM6_ALU_MUL_EN`
  - Defined: MUL implemented as above.
  - Undefined: no multiplier datapath. Opcode 10 is treated as illegal, with latency 2, r=y=0 and `illegal`=1.
- All other opcodes are unaffected either way.

## Test plan
- Reset with `start` held high for 3 cycles → all outputs 0, FSM stays IDLE, no `done`.
- ADD a=0xFFFF_FFFF_FFFF, b=1 → `done` 2 cycles after start, r=0, y=1. SUB a=3, b=5 → r=0xFFFF_FFFF_FFFE, y=1.
- PLUS_OFFSET a=0x100, b=0x05 → r=0x154. b=0x13 → r=0x10C.
- SHIFT a=0x8000_0000_0001:
  - Left by 4 → r=0x0000_0000_0010, y=0x8, latency 6.
  - Right by 1 (b=0x41) → r=0x4000_0000_0000, y=0x8000_0000_0000.
  - n=0 → latency 2, r=a.
  - n=63 → clamped to 48.
- MUL a=0xFFFF_FFFF_FFFF, b=2 → r=1, y=0xFFFF_FFFF_FFFE, `done` at cycle 50. With the macro undefined → `illegal`=1, latency 2.
- Mid-MUL: `start` with a new op at cycle 10 → ignored. `reset` at cycle 20 → outputs 0, no `done`. A following NOT a=0 → r=0xFFFF_FFFF_FFFF.
